// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith/shift ops plus iterative MUL (shift-and-add)
// and DIVU/REMU (restoring division), one bit per clock.
module multicycle_alu #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] operand1,
    input  logic [DATA_WIDTH-1:0] operand2,
    input  logic [SEL_WIDTH-1:0]  opSel,
    output logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero
);

    localparam int SHW = $clog2(DATA_WIDTH);
    localparam int CW  = $clog2(DATA_WIDTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [SEL_WIDTH-1:0] OP_ADD  = SEL_WIDTH'(0);
    localparam logic [SEL_WIDTH-1:0] OP_SUB  = SEL_WIDTH'(1);
    localparam logic [SEL_WIDTH-1:0] OP_AND  = SEL_WIDTH'(2);
    localparam logic [SEL_WIDTH-1:0] OP_OR   = SEL_WIDTH'(3);
    localparam logic [SEL_WIDTH-1:0] OP_XOR  = SEL_WIDTH'(4);
    localparam logic [SEL_WIDTH-1:0] OP_NOR  = SEL_WIDTH'(5);
    localparam logic [SEL_WIDTH-1:0] OP_SLT  = SEL_WIDTH'(6);
    localparam logic [SEL_WIDTH-1:0] OP_SGT  = SEL_WIDTH'(7);
    localparam logic [SEL_WIDTH-1:0] OP_SLL  = SEL_WIDTH'(8);
    localparam logic [SEL_WIDTH-1:0] OP_SRL  = SEL_WIDTH'(9);
    localparam logic [SEL_WIDTH-1:0] OP_SRA  = SEL_WIDTH'(10);
    localparam logic [SEL_WIDTH-1:0] OP_SLTU = SEL_WIDTH'(11);
    localparam logic [SEL_WIDTH-1:0] OP_MUL  = SEL_WIDTH'(12);
    localparam logic [SEL_WIDTH-1:0] OP_DIVU = SEL_WIDTH'(13);
    localparam logic [SEL_WIDTH-1:0] OP_REMU = SEL_WIDTH'(14);

    localparam logic [CW-1:0]         CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]         CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]         CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] D_ZERO   = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] D_ONES   = {DATA_WIDTH{1'b1}};

    // Single-cycle operations; multicycle codes never reach here with a used result.
    function automatic logic [DATA_WIDTH-1:0] alu_f(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic [SEL_WIDTH-1:0]  op
    );
        logic [SHW-1:0] shamt;
        shamt = b[SHW-1:0];
        case (op)
            OP_ADD:  alu_f = a + b;
            OP_SUB:  alu_f = a - b;
            OP_AND:  alu_f = a & b;
            OP_OR:   alu_f = a | b;
            OP_XOR:  alu_f = a ^ b;
            OP_NOR:  alu_f = ~(a | b);
            OP_SLT:  alu_f = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SGT:  alu_f = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
            OP_SLL:  alu_f = a << shamt;
            OP_SRL:  alu_f = a >> shamt;
            OP_SRA:  alu_f = $signed(a) >>> shamt;
            OP_SLTU: alu_f = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
            default: alu_f = D_ONES;
        endcase
    endfunction

    logic [0:0]            state_r;
    logic [CW-1:0]         cnt_r;
    logic [SEL_WIDTH-1:0]  op_r;
    logic [DATA_WIDTH-1:0] acc_r;   // partial product / remainder
    logic [DATA_WIDTH-1:0] opb_r;   // shifting multiplicand / divisor
    logic [DATA_WIDTH-1:0] sh_r;    // multiplier / dividend shifting into quotient
    logic [DATA_WIDTH-1:0] result_r;
    logic                  valid_r;

    logic [DATA_WIDTH-1:0] acc_nx_s;
    logic [DATA_WIDTH-1:0] opb_nx_s;
    logic [DATA_WIDTH-1:0] sh_nx_s;
    logic [DATA_WIDTH+1:0] trial_s;
    logic [DATA_WIDTH-1:0] final_s;
    logic                  is_multi_s;

    // One shift-and-add or restoring-division step on the iteration registers.
    always_comb begin
        acc_nx_s = acc_r;
        opb_nx_s = opb_r;
        sh_nx_s  = sh_r;
        trial_s  = {(DATA_WIDTH+2){1'b0}};
        if (op_r == OP_MUL) begin
            if (sh_r[0]) begin
                acc_nx_s = acc_r + opb_r;
            end else begin
                acc_nx_s = acc_r;
            end
            opb_nx_s = {opb_r[DATA_WIDTH-2:0], 1'b0};
            sh_nx_s  = {1'b0, sh_r[DATA_WIDTH-1:1]};
        end else begin
            // Extra headroom bit makes the MSB a clean borrow flag.
            trial_s = {1'b0, acc_r, sh_r[DATA_WIDTH-1]} - {2'b00, opb_r};
            if (!trial_s[DATA_WIDTH+1]) begin
                acc_nx_s = trial_s[DATA_WIDTH-1:0];
                sh_nx_s  = {sh_r[DATA_WIDTH-2:0], 1'b1};
            end else begin
                acc_nx_s = {acc_r[DATA_WIDTH-2:0], sh_r[DATA_WIDTH-1]};
                sh_nx_s  = {sh_r[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    // Select the finished multicycle result from the last iteration step.
    always_comb begin
        case (op_r)
            OP_MUL:  final_s = acc_nx_s;
            OP_DIVU: final_s = sh_nx_s;
            OP_REMU: final_s = acc_nx_s;
            default: final_s = D_ONES;
        endcase
        is_multi_s = (opSel == OP_MUL) || (opSel == OP_DIVU) || (opSel == OP_REMU);
    end

    // Control FSM, iteration registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= CNT_ZERO;
            op_r     <= OP_ADD;
            acc_r    <= D_ZERO;
            opb_r    <= D_ZERO;
            sh_r     <= D_ZERO;
            result_r <= D_ZERO;
            valid_r  <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r <= opSel;
                        if (is_multi_s) begin
                            state_r <= BUSY;
                            cnt_r   <= CNT_LAST;
                            acc_r   <= D_ZERO;
                            if (opSel == OP_MUL) begin
                                opb_r <= operand1;
                                sh_r  <= operand2;
                            end else begin
                                opb_r <= operand2;
                                sh_r  <= operand1;
                            end
                        end else begin
                            result_r <= alu_f(operand1, operand2, opSel);
                            valid_r  <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    acc_r <= acc_nx_s;
                    opb_r <= opb_nx_s;
                    sh_r  <= sh_nx_s;
                    if (cnt_r == CNT_ZERO) begin
                        state_r  <= IDLE;
                        result_r <= final_s;
                        valid_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign ready  = (state_r == IDLE);
    assign valid  = valid_r;
    assign result = result_r;
    assign zero   = (result_r == D_ZERO);

endmodule
